lfsr_modulator: RTL and testbench

//  Consumer stage for the N-bit LFSR random-bit source. Synchronises LFSR bit 0

---
 rtl/lfsr_modulator.sv | 147 ++++++++++++++
 tb/tb_lfsr_modulator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_modulator.sv
// LFSR-driven modulator: brings the LFSR data bit into the DDS clock domain,
// finds symbol boundaries, and applies the bit to DDS samples as ASK/FSK/BPSK/square.
module lfsr_modulator #(
  parameter int N = 5,
  parameter int W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        lfsr_q,
  input  logic [1:0]          mod_sel,
  input  logic signed [W-1:0] sin_in,
  input  logic signed [W-1:0] cos_in,
  input  logic [31:0]         freq_lo,
  input  logic [31:0]         freq_hi,
  output logic [31:0]         phase_inc,
  output logic signed [W-1:0] mod_out,
  output logic                bit_sync,
  output logic                bit_edge,
  output logic [1:0]          mode,
  output logic [15:0]         edge_count
);

  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] SNEG = -SMAX;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 s1_q, s1_d;
  logic                 s2_q, s2_d;
  logic                 bit_sync_q, bit_sync_d;
  logic                 bit_edge_q, bit_edge_d;
  logic [1:0]           mode_q, mode_d;
  logic [15:0]          edge_count_q, edge_count_d;
  logic signed [W-1:0]  mod_out_q, mod_out_d;
  logic [31:0]          phase_inc_q, phase_inc_d;
  logic                 edge_s;
  logic signed [W-1:0]  neg_sin_s;
  logic                 unused_inputs_s;

  // Only bit 0 of the LFSR carries data; cos_in is a monitor-only input.
  assign unused_inputs_s = ^{cos_in, lfsr_q[N-1:1]};

  // State register for the synchroniser, FSM, counter and output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      bit_sync_q   <= 1'b0;
      bit_edge_q   <= 1'b0;
      mode_q       <= 2'b00;
      edge_count_q <= 16'h0000;
      mod_out_q    <= '0;
      phase_inc_q  <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      bit_sync_q   <= bit_sync_d;
      bit_edge_q   <= bit_edge_d;
      mode_q       <= mode_d;
      edge_count_q <= edge_count_d;
      mod_out_q    <= mod_out_d;
      phase_inc_q  <= phase_inc_d;
    end
  end

  // Synchroniser, boundary detect, saturating boundary counter.
  always_comb begin
    s1_d       = lfsr_q[0];
    s2_d       = s1_q;
    bit_sync_d = s2_q;
    edge_s     = s2_q ^ bit_sync_q;
    bit_edge_d = edge_s;
    if (edge_s && (edge_count_q != 16'hFFFF)) begin
      edge_count_d = edge_count_q + 16'd1;
    end else begin
      edge_count_d = edge_count_q;
    end
  end

  // Mode FSM: scheme is latched once after reset, then only at symbol boundaries.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      ST_INIT: begin
        mode_d  = mod_sel;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (edge_s) begin
          mode_d = mod_sel;
        end else begin
          mode_d = mode_q;
        end
      end
      default: begin
        state_d = ST_INIT;
        mode_d  = 2'b00;
      end
    endcase
  end

  // Modulation output stage, driven from the registered bit and mode.
  always_comb begin
    mod_out_d   = '0;
    phase_inc_d = freq_lo;
    if (sin_in == SMIN) begin
      neg_sin_s = SMAX;
    end else begin
      neg_sin_s = -sin_in;
    end
    case (mode_q)
      2'b00: begin
        mod_out_d = bit_sync_q ? sin_in : '0;
      end
      2'b01: begin
        mod_out_d   = sin_in;
        phase_inc_d = bit_sync_q ? freq_hi : freq_lo;
      end
      2'b10: begin
        mod_out_d = bit_sync_q ? sin_in : neg_sin_s;
      end
      2'b11: begin
        mod_out_d = bit_sync_q ? SMAX : SNEG;
      end
      default: begin
        mod_out_d   = '0;
        phase_inc_d = freq_lo;
      end
    endcase
  end

  assign phase_inc  = phase_inc_q;
  assign mod_out    = mod_out_q;
  assign bit_sync   = bit_sync_q;
  assign bit_edge   = bit_edge_q;
  assign mode       = mode_q;
  assign edge_count = edge_count_q;

endmodule

// File: tb/tb_lfsr_modulator.sv
// Self-checking bench for lfsr_modulator: directed latency/saturation/mode cases,
// randomized traffic and counter saturation, all against a sample-history model.
module tb_lfsr_modulator;

  localparam int N = 5;
  localparam int W = 12;
  localparam logic [31:0] F_LO = 32'h0100_0000;
  localparam logic [31:0] F_HI = 32'h0200_0000;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [N-1:0]        lfsr_q = '0;
  logic [1:0]          mod_sel = 2'b00;
  logic signed [W-1:0] sin_in = '0;
  logic signed [W-1:0] cos_in = '0;
  logic [31:0]         freq_lo = F_LO;
  logic [31:0]         freq_hi = F_HI;
  logic [31:0]         phase_inc;
  logic signed [W-1:0] mod_out;
  logic                bit_sync;
  logic                bit_edge;
  logic [1:0]          mode;
  logic [15:0]         edge_count;

  int checks = 0;
  int errors = 0;

  // model state: last four sampled lfsr bits, oldest first
  bit          smp[$];
  bit          first;
  bit          e_bs, e_edge;
  logic [1:0]  e_mode;
  int          e_cnt;
  int          e_out;
  logic [31:0] e_pinc;

  lfsr_modulator #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .lfsr_q(lfsr_q), .mod_sel(mod_sel),
    .sin_in(sin_in), .cos_in(cos_in), .freq_lo(freq_lo), .freq_hi(freq_hi),
    .phase_inc(phase_inc), .mod_out(mod_out), .bit_sync(bit_sync),
    .bit_edge(bit_edge), .mode(mode), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int model_out(input bit bs, input logic [1:0] md, input int s);
    case (md)
      2'b00: return bs ? s : 0;
      2'b01: return s;
      2'b10: return bs ? s : ((s == -2048) ? 2047 : -s);
      default: return bs ? 2047 : -2047;
    endcase
  endfunction

  task automatic model_reset();
    smp = '{1'b0, 1'b0, 1'b0, 1'b0};
    first = 1'b1;
    e_bs = 1'b0; e_edge = 1'b0; e_mode = 2'b00;
    e_cnt = 0; e_out = 0; e_pinc = 32'h0;
  endtask

  // One clock: model advances on the edge, outputs compared at the falling edge.
  task automatic tick();
    bit          p_bs;
    logic [1:0]  p_mode;
    bit          chg;
    @(posedge clk);
    p_bs = e_bs;
    p_mode = e_mode;
    smp.push_back(lfsr_q[0]);
    void'(smp.pop_front());
    chg = (smp[1] != smp[0]);
    e_bs = smp[1];
    e_edge = chg;
    if (first || chg) e_mode = mod_sel;
    first = 1'b0;
    if (chg && e_cnt < 65535) e_cnt++;
    e_out = model_out(p_bs, p_mode, int'(sin_in));
    e_pinc = (p_mode == 2'b01 && p_bs) ? freq_hi : freq_lo;
    @(negedge clk);
    chk("bit_sync", bit_sync, e_bs);
    chk("bit_edge", bit_edge, e_edge);
    chk("mode", mode, e_mode);
    chk("edge_count", edge_count, e_cnt);
    chk("mod_out", $signed(mod_out), e_out);
    chk("phase_inc", phase_inc, e_pinc);
  endtask

  // Mid-cycle asynchronous reset; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_mod_out", $signed(mod_out), 0);
    chk("rst_phase_inc", phase_inc, 0);
    chk("rst_bit_sync", bit_sync, 0);
    chk("rst_bit_edge", bit_edge, 0);
    chk("rst_mode", mode, 0);
    chk("rst_edge_count", edge_count, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // latency: ASK, bit rises before E0
    mod_sel = 2'b00; sin_in = 12'sd1000; lfsr_q = 5'b00000;
    repeat (3) tick();
    lfsr_q = 5'b00001;
    tick();
    chk("lat_e0_bit_sync", bit_sync, 0);
    chk("lat_e0_bit_edge", bit_edge, 0);
    tick();
    chk("lat_e1_bit_edge", bit_edge, 0);
    tick();
    chk("lat_e2_bit_edge", bit_edge, 1);
    chk("lat_e2_bit_sync", bit_sync, 1);
    chk("lat_e2_mod_out", $signed(mod_out), 0);
    tick();
    chk("lat_e3_mod_out", $signed(mod_out), 1000);
    chk("lat_e3_bit_edge", bit_edge, 0);

    // reset mid-run with bit_sync=1 and mod_out!=0; INIT then loads BPSK
    mod_sel = 2'b10; lfsr_q = 5'b00000;
    do_reset();
    tick();
    chk("init_mode", mode, 2);

    // BPSK saturation
    sin_in = -12'sd2048;
    tick();
    chk("bpsk_sat", $signed(mod_out), 2047);
    sin_in = 12'sd500;
    tick();
    chk("bpsk_neg", $signed(mod_out), -500);
    sin_in = -12'sd2048; lfsr_q = 5'b00001;
    repeat (4) tick();
    chk("bpsk_pos_min", $signed(mod_out), -2048);

    // FSK switching
    mod_sel = 2'b01; lfsr_q = 5'b00000;
    repeat (4) tick();
    chk("fsk_lo", phase_inc, F_LO);
    lfsr_q = 5'b10001;
    repeat (3) tick();
    chk("fsk_e2_still_lo", phase_inc, F_LO);
    tick();
    chk("fsk_e3_hi", phase_inc, F_HI);
    lfsr_q = 5'b00110;
    repeat (3) tick();
    chk("fsk_e2_still_hi", phase_inc, F_HI);
    tick();
    chk("fsk_e3_lo", phase_inc, F_LO);

    // deferred mode change
    mod_sel = 2'b00; lfsr_q = 5'b00001;
    repeat (4) tick();
    mod_sel = 2'b11;
    repeat (5) tick();
    chk("defer_hold", mode, 0);
    lfsr_q = 5'b00000;
    repeat (2) tick();
    chk("defer_e1", mode, 0);
    tick();
    chk("defer_e2", mode, 3);
    tick();
    chk("sqr_neg", $signed(mod_out), -2047);
    lfsr_q = 5'b00001;
    repeat (4) tick();
    chk("sqr_pos", $signed(mod_out), 2047);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int hold;
      hold = int'($urandom_range(1, 6));
      lfsr_q = N'($urandom);
      if ($urandom_range(0, 3) == 0) mod_sel = 2'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        freq_lo = $urandom;
        freq_hi = $urandom;
      end
      if ($urandom_range(0, 150) == 0) do_reset();
      for (int j = 0; j < hold; j++) begin
        sin_in = ($urandom_range(0, 9) == 0) ? -12'sd2048 : W'($urandom);
        cos_in = W'($urandom);
        tick();
      end
    end

    // counter saturation
    do_reset();
    for (int i = 0; i < 65537; i++) begin
      lfsr_q[0] = ~lfsr_q[0];
      tick();
    end
    repeat (4) tick();
    chk("count_sat", edge_count, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
